// File: rtl/systolic_2x2_if.sv
// Bus between the matrix-multiply controller and the 2x2 systolic MAC array.
//   master: controller side (drives step strobe and operand wavefronts, reads results)
//   slave : array side (consumes operands, presents accumulators, carries and done)
interface systolic_2x2_if;
    localparam int unsigned OP_W  = 32;
    localparam int unsigned ACC_W = 64;

    logic             load_in;
    logic [OP_W-1:0]  row_in_row0;
    logic [OP_W-1:0]  row_in_row1;
    logic [OP_W-1:0]  col_in_col0;
    logic [OP_W-1:0]  col_in_col1;
    logic [ACC_W-1:0] result_row00;
    logic [ACC_W-1:0] result_row01;
    logic [ACC_W-1:0] result_row10;
    logic [ACC_W-1:0] result_row11;
    logic             carry_00;
    logic             carry_01;
    logic             carry_10;
    logic             carry_11;
    logic             done;

    modport master (
        output load_in, row_in_row0, row_in_row1, col_in_col0, col_in_col1,
        input  result_row00, result_row01, result_row10, result_row11,
        input  carry_00, carry_01, carry_10, carry_11, done
    );

    modport slave (
        input  load_in, row_in_row0, row_in_row1, col_in_col0, col_in_col1,
        output result_row00, result_row01, result_row10, result_row11,
        output carry_00, carry_01, carry_10, carry_11, done
    );
endinterface

// File: rtl/systolic_2x2.sv
// Output-stationary 2x2 systolic multiply-accumulate array (C = A*B).
// Each accepted load_in advances the array one systolic step: every PE adds
// a*b into its 64-bit accumulator and forwards a right and b down.
// Ports:
//   clk       : rising-edge clock
//   rst       : asynchronous active-high reset
//   bus.slave : load_in, row_in_row0/1, col_in_col0/1 in;
//               result_row00..11, carry_00..11, done out (all registered)
module systolic_2x2 #(
    parameter logic [2:0] DATA_TYPE = 3'b011
) (
    input  logic          clk,
    input  logic          rst,
    systolic_2x2_if.slave bus
);
    localparam int unsigned OP_W   = 32;
    localparam int unsigned ACC_W  = 64;
    localparam int unsigned NUM_PE = 4;
    localparam bit IS_SIGNED = (DATA_TYPE == 3'b001) || (DATA_TYPE == 3'b100) ||
                               (DATA_TYPE == 3'b101);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LATCH,
        S_MAC,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [OP_W-1:0]  row0_q, row1_q, col0_q, col1_q;
    logic [OP_W-1:0]  a_fwd00_q, b_fwd00_q, a_fwd10_q, b_fwd01_q;
    logic [ACC_W-1:0] acc_q [NUM_PE];
    logic [NUM_PE-1:0] carry_q;
    logic             done_q;

    logic [OP_W-1:0]  a_op    [NUM_PE];
    logic [OP_W-1:0]  b_op    [NUM_PE];
    logic [ACC_W:0]   mac_res [NUM_PE];

    // Operand width/sign extension selected by DATA_TYPE.
    function automatic logic [ACC_W-1:0] extend(input logic [OP_W-1:0] v);
        logic [ACC_W-1:0] r;
        case (DATA_TYPE)
            3'b000:  r = {{(ACC_W-8){1'b0}}, v[7:0]};
            3'b001:  r = {{(ACC_W-8){v[7]}}, v[7:0]};
            3'b010:  r = {{(ACC_W-16){1'b0}}, v[15:0]};
            3'b100:  r = {{(ACC_W-16){v[15]}}, v[15:0]};
            3'b101:  r = {{(ACC_W-OP_W){v[OP_W-1]}}, v};
            default: r = {{(ACC_W-OP_W){1'b0}}, v};
        endcase
        return r;
    endfunction

    // Returns {overflow, acc + a*b mod 2^64}; overflow meaning depends on signedness.
    function automatic logic [ACC_W:0] mac_step(input logic [ACC_W-1:0] acc,
                                                input logic [OP_W-1:0]  a,
                                                input logic [OP_W-1:0]  b);
        logic [ACC_W-1:0] prod;
        logic [ACC_W:0]   wide;
        logic             ovf;
        prod = extend(a) * extend(b);
        wide = {1'b0, acc} + {1'b0, prod};
        if (IS_SIGNED) begin
            ovf = (acc[ACC_W-1] == prod[ACC_W-1]) && (wide[ACC_W-1] != acc[ACC_W-1]);
        end else begin
            ovf = wide[ACC_W];
        end
        return {ovf, wide[ACC_W-1:0]};
    endfunction

    // Operand routing: edge PEs take latched ports, inner PEs take neighbour forwards.
    always_comb begin
        a_op[0] = row0_q;
        b_op[0] = col0_q;
        a_op[1] = a_fwd00_q;
        b_op[1] = col1_q;
        a_op[2] = row1_q;
        b_op[2] = b_fwd00_q;
        a_op[3] = a_fwd10_q;
        b_op[3] = b_fwd01_q;
        for (int p = 0; p < NUM_PE; p++) begin
            mac_res[p] = mac_step(acc_q[p], a_op[p], b_op[p]);
        end
    end

    // Step controller and all datapath state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            row0_q    <= '0;
            row1_q    <= '0;
            col0_q    <= '0;
            col1_q    <= '0;
            a_fwd00_q <= '0;
            b_fwd00_q <= '0;
            a_fwd10_q <= '0;
            b_fwd01_q <= '0;
            carry_q   <= '0;
            done_q    <= 1'b0;
            for (int p = 0; p < NUM_PE; p++) begin
                acc_q[p] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.load_in) begin
                        row0_q  <= bus.row_in_row0;
                        row1_q  <= bus.row_in_row1;
                        col0_q  <= bus.col_in_col0;
                        col1_q  <= bus.col_in_col1;
                        state_q <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    for (int p = 0; p < NUM_PE; p++) begin
                        acc_q[p]   <= mac_res[p][ACC_W-1:0];
                        carry_q[p] <= carry_q[p] | mac_res[p][ACC_W];
                    end
                    a_fwd00_q <= row0_q;
                    b_fwd00_q <= col0_q;
                    a_fwd10_q <= row1_q;
                    b_fwd01_q <= col1_q;
                    state_q   <= S_MAC;
                end
                S_MAC: begin
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    done_q <= 1'b0;
                    // The edge that leaves DONE is the first legal slot for the
                    // next step, so a strobe here is taken as if already idle.
                    if (bus.load_in) begin
                        row0_q  <= bus.row_in_row0;
                        row1_q  <= bus.row_in_row1;
                        col0_q  <= bus.col_in_col0;
                        col1_q  <= bus.col_in_col1;
                        state_q <= S_LATCH;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.result_row00 = acc_q[0];
    assign bus.result_row01 = acc_q[1];
    assign bus.result_row10 = acc_q[2];
    assign bus.result_row11 = acc_q[3];
    assign bus.carry_00     = carry_q[0];
    assign bus.carry_01     = carry_q[1];
    assign bus.carry_10     = carry_q[2];
    assign bus.carry_11     = carry_q[3];
    assign bus.done         = done_q;
endmodule

// File: tb/tb_systolic_2x2.sv
// Scoreboard bench for systolic_2x2: four instances (uint32, int32, int8, uint8)
// share one stimulus stream; an integer-arithmetic model predicts each step.
module tb_systolic_2x2;
    localparam int unsigned NDUT = 4;
    localparam logic [NDUT-1:0][2:0] TYPES = {3'b000, 3'b001, 3'b101, 3'b011};

    typedef struct packed {
        logic [NDUT-1:0][3:0][63:0] res;
        logic [NDUT-1:0][3:0]       cy;
        int                         due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [31:0] r0, r1, c0, c1;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    logic [63:0] res_w  [NDUT][4];
    logic [3:0]  cy_w   [NDUT];
    logic        done_w [NDUT];

    exp_t        sb_q[$];
    logic [63:0] m_acc [NDUT][4];
    logic        m_cy  [NDUT][4];
    logic [31:0] h_row [2][2];
    logic [31:0] h_col [2][2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        systolic_2x2_if bus ();
        assign bus.load_in     = load;
        assign bus.row_in_row0 = r0;
        assign bus.row_in_row1 = r1;
        assign bus.col_in_col0 = c0;
        assign bus.col_in_col1 = c1;
        assign res_w[g][0]     = bus.result_row00;
        assign res_w[g][1]     = bus.result_row01;
        assign res_w[g][2]     = bus.result_row10;
        assign res_w[g][3]     = bus.result_row11;
        assign cy_w[g]         = {bus.carry_11, bus.carry_10, bus.carry_01, bus.carry_00};
        assign done_w[g]       = bus.done;
        systolic_2x2 #(.DATA_TYPE(TYPES[g])) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus.slave)
        );
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit is_signed_t(input logic [2:0] t);
        return (t == 3'b001) || (t == 3'b100) || (t == 3'b101);
    endfunction

    // Mathematical value of a port word interpreted as the given operand type.
    function automatic logic signed [127:0] opval(input logic [2:0] t, input logic [31:0] x);
        case (t)
            3'b000:  return {120'd0, x[7:0]};
            3'b001:  return {{120{x[7]}}, x[7:0]};
            3'b010:  return {112'd0, x[15:0]};
            3'b100:  return {{112{x[15]}}, x[15:0]};
            3'b101:  return {{96{x[31]}}, x};
            default: return {96'd0, x};
        endcase
    endfunction

    task automatic model_clear();
        for (int k = 0; k < NDUT; k++)
            for (int p = 0; p < 4; p++) begin
                m_acc[k][p] = '0;
                m_cy[k][p]  = 1'b0;
            end
        for (int i = 0; i < 2; i++)
            for (int d = 0; d < 2; d++) begin
                h_row[i][d] = '0;
                h_col[i][d] = '0;
            end
    endtask

    // PE(i,j) sees row i delayed by j steps and column j delayed by i steps.
    task automatic model_step(input logic [31:0] a0, a1, b0, b1);
        logic signed [127:0] prod, exact;
        logic                ovf;
        int                  pe;
        h_row[0][1] = h_row[0][0]; h_row[0][0] = a0;
        h_row[1][1] = h_row[1][0]; h_row[1][0] = a1;
        h_col[0][1] = h_col[0][0]; h_col[0][0] = b0;
        h_col[1][1] = h_col[1][0]; h_col[1][0] = b1;
        for (int k = 0; k < NDUT; k++)
            for (int i = 0; i < 2; i++)
                for (int j = 0; j < 2; j++) begin
                    pe   = i * 2 + j;
                    prod = opval(TYPES[k], h_row[i][j]) * opval(TYPES[k], h_col[j][i]);
                    if (is_signed_t(TYPES[k])) begin
                        exact = $signed({{64{m_acc[k][pe][63]}}, m_acc[k][pe]}) + prod;
                        ovf   = (exact != $signed({{64{exact[63]}}, exact[63:0]}));
                    end else begin
                        exact = $signed({64'd0, m_acc[k][pe]}) + prod;
                        ovf   = (exact[127:64] != 64'd0);
                    end
                    m_acc[k][pe] = exact[63:0];
                    m_cy[k][pe]  = m_cy[k][pe] | ovf;
                end
    endtask

    // Issue one step; load held for 'hold' edges, next step may follow 'gap' cycles later.
    task automatic do_step(input logic [31:0] a0, a1, b0, b1, input int gap, input int hold = 1);
        exp_t e;
        @(negedge clk);
        r0 = a0; r1 = a1; c0 = b0; c1 = b1;
        load = 1'b1;
        model_step(a0, a1, b0, b1);
        for (int k = 0; k < NDUT; k++)
            for (int p = 0; p < 4; p++) begin
                e.res[k][p] = m_acc[k][p];
                e.cy[k][p]  = m_cy[k][p];
            end
        e.due = cyc + 3;
        sb_q.push_back(e);
        repeat (hold) @(posedge clk);
        @(negedge clk);
        load = 1'b0;
        repeat (gap - hold - 1) @(negedge clk);
    endtask

    task automatic drain();
        repeat (4) @(negedge clk);
        check("sb_drain", 64'(sb_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        drain();
        @(negedge clk);
        rst  = 1'b1;
        load = 1'b0;
        model_clear();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic expect_pe(input int k, input int p, input logic [63:0] v, input logic cy);
        check($sformatf("direct_d%0d_res%0d", k, p), res_w[k][p], v);
        check($sformatf("direct_d%0d_cy%0d", k, p), 64'(cy_w[k][p]), 64'(cy));
    endtask

    // Monitor: at every done (expected or not) compare against the scoreboard head.
    always @(negedge clk) begin
        bit   exp_done;
        bit   any_done;
        exp_t e;
        if (!rst) begin
            exp_done = (sb_q.size() > 0) && (sb_q[0].due == cyc);
            any_done = 1'b0;
            for (int k = 0; k < NDUT; k++) any_done |= done_w[k];
            if (exp_done || any_done) begin
                for (int k = 0; k < NDUT; k++)
                    check($sformatf("d%0d_done", k), 64'(done_w[k]), 64'(exp_done));
                if (exp_done) begin
                    e = sb_q.pop_front();
                    for (int k = 0; k < NDUT; k++)
                        for (int p = 0; p < 4; p++) begin
                            check($sformatf("d%0d_res%0d", k, p), res_w[k][p], e.res[k][p]);
                            check($sformatf("d%0d_cy%0d", k, p), 64'(cy_w[k][p]), 64'(e.cy[k][p]));
                        end
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish (got running, expected finished)");
        $fatal(1);
    end

    initial begin
        logic [31:0] v [4];
        rst = 1'b1; load = 1'b0; r0 = '0; r1 = '0; c0 = '0; c1 = '0;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            for (int p = 0; p < 4; p++) expect_pe(k, p, 64'd0, 1'b0);
            check($sformatf("reset_d%0d_done", k), 64'(done_w[k]), 64'd0);
        end

        // A = B = [[1,2],[3,4]] via the four-step skewed schedule.
        do_step(32'd2, 32'd0, 32'd3, 32'd0, 21);
        do_step(32'd1, 32'd4, 32'd1, 32'd4, 21);
        do_step(32'd0, 32'd3, 32'd0, 32'd2, 21);
        do_step(32'd0, 32'd0, 32'd0, 32'd0, 21);
        drain();
        for (int k = 0; k < NDUT; k++) begin
            expect_pe(k, 0, 64'd7, 1'b0);
            expect_pe(k, 1, 64'd10, 1'b0);
            expect_pe(k, 2, 64'd15, 1'b0);
            expect_pe(k, 3, 64'd22, 1'b0);
        end

        // Single step.
        do_reset();
        do_step(32'd5, 32'd0, 32'd6, 32'd0, 4);
        drain();
        expect_pe(0, 0, 64'd30, 1'b0);
        expect_pe(0, 1, 64'd0, 1'b0);
        expect_pe(0, 2, 64'd0, 1'b0);
        expect_pe(0, 3, 64'd0, 1'b0);

        // load_in held through LATCH and MAC: only one accumulation.
        do_reset();
        do_step(32'd7, 32'd0, 32'd7, 32'd0, 5, 3);
        drain();
        expect_pe(0, 0, 64'd49, 1'b0);

        // Unsigned wrap and sticky carry; steps spaced at the 3-cycle minimum.
        do_reset();
        do_step(32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 32'd0, 3);
        do_step(32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 32'd0, 3);
        do_step(32'd0, 32'd0, 32'd0, 32'd0, 3);
        drain();
        expect_pe(0, 0, 64'hFFFF_FFFC_0000_0002, 1'b1);

        // Signed products.
        do_reset();
        do_step(32'hFFFF_FFFE, 32'd0, 32'd3, 32'd0, 4);
        drain();
        expect_pe(1, 0, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0);
        do_reset();
        do_step(32'h0000_00FE, 32'd0, 32'd3, 32'd0, 4);
        drain();
        expect_pe(2, 0, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0);
        expect_pe(0, 0, 64'd762, 1'b0);

        // Reset mid-step aborts the step and clears everything.
        do_reset();
        do_step(32'd10, 32'd0, 32'd10, 32'd0, 4);
        drain();
        @(negedge clk);
        r0 = 32'd9; c0 = 32'd9; r1 = '0; c1 = '0;
        load = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
        rst  = 1'b1;
        model_clear();
        #1;
        check("abort_async_res00", res_w[0][0], 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        for (int p = 0; p < 4; p++) expect_pe(0, p, 64'd0, 1'b0);
        check("abort_no_done", 64'(done_w[0]), 64'd0);
        do_step(32'd5, 32'd0, 32'd6, 32'd0, 4);
        drain();
        expect_pe(0, 0, 64'd30, 1'b0);

        // Randomized wavefronts across all operand types.
        do_reset();
        for (int n = 0; n < 40; n++) begin
            for (int q = 0; q < 4; q++) begin
                case ($urandom_range(0, 5))
                    0:       v[q] = 32'hFFFF_FFFF;
                    1:       v[q] = 32'h8000_0000;
                    2:       v[q] = 32'h7FFF_FF80;
                    default: v[q] = $urandom;
                endcase
            end
            do_step(v[0], v[1], v[2], v[3], $urandom_range(3, 6));
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
